// File: rtl/scr1_ahb_sram_slave_pkg.sv
// Shared AHB-Lite definitions for the SCR1 SRAM responder.
//   - bus width, htrans / hsize / hresp encodings (SCR1 1-bit hresp)
//   - responder FSM state type
//   - byte-lane enable helper for byte/halfword/word writes
package scr1_ahb_sram_slave_pkg;

    localparam int SCR1_AHB_WIDTH = 32;

    localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] SCR1_HSIZE_8BIT  = 3'b000;
    localparam logic [2:0] SCR1_HSIZE_16BIT = 3'b001;
    localparam logic [2:0] SCR1_HSIZE_32BIT = 3'b010;

    localparam logic SCR1_HRESP_OKAY  = 1'b0;
    localparam logic SCR1_HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        SCR1_AHB_SLV_FSM_IDLE,
        SCR1_AHB_SLV_FSM_WAIT,
        SCR1_AHB_SLV_FSM_DONE,
        SCR1_AHB_SLV_FSM_ERR1,
        SCR1_AHB_SLV_FSM_ERR2
    } type_scr1_ahb_slv_fsm_e;

    // Lane enables for an aligned access; callers reject misaligned ones.
    function automatic logic [3:0] scr1_ahb_byte_en(input logic [2:0] size,
                                                    input logic [1:0] offs);
        logic [3:0] be;
        case (size)
            SCR1_HSIZE_8BIT:  be = 4'b0001 << offs;
            SCR1_HSIZE_16BIT: be = offs[1] ? 4'b1100 : 4'b0011;
            default:          be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/scr1_sram_1rw_be.sv
// Single-port 2^AW x 32 SRAM, synchronous byte-enabled write, asynchronous read.
// Written so FPGA tools infer distributed/block RAM. Contents are never reset.
//   clk   : write clock
//   we    : write strobe, qualified per lane by be
//   be    : byte-lane enables
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : read data, combinational from addr
module scr1_sram_1rw_be #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/scr1_ahb_sram_slave.sv
// AHB-Lite responder with a word-organized SRAM behind it, for the SCR1
// imem/dmem ports in FPGA/emulation builds.
//   clk, rst_n        : clock, asynchronous active-low reset
//   hsel..hready      : AHB-Lite address/data phase inputs
//   stall             : holds a pending OKAY data phase in wait
//   hreadyout, hrdata,
//   hresp             : AHB-Lite responder outputs (hresp 1 = ERROR)
//
// state | meaning
// IDLE  | no data phase pending
// WAIT  | OKAY data phase, inserting wait states / stalled
// DONE  | OKAY data phase completes this cycle (write commits at its end)
// ERR1  | first ERROR cycle, hreadyout low
// ERR2  | second ERROR cycle, hreadyout high
module scr1_ahb_sram_slave
    import scr1_ahb_sram_slave_pkg::*;
#(
    parameter int                        MEM_AW      = 14,
    parameter int                        WAIT_STATES = 0,
    parameter logic [SCR1_AHB_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hsel,
    input  logic [SCR1_AHB_WIDTH-1:0] haddr,
    input  logic [1:0]                htrans,
    input  logic [2:0]                hsize,
    input  logic                      hwrite,
    input  logic [SCR1_AHB_WIDTH-1:0] hwdata,
    input  logic                      hready,
    input  logic                      stall,
    output logic                      hreadyout,
    output logic [SCR1_AHB_WIDTH-1:0] hrdata,
    output logic                      hresp
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    type_scr1_ahb_slv_fsm_e state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [MEM_AW-1:0]      waddr_q, waddr_d;
    logic [1:0]             boff_q, boff_d;
    logic [2:0]             size_q, size_d;
    logic                   write_q, write_d;

    logic                      accept;
    logic [SCR1_AHB_WIDTH-1:0] addr_off;
    logic                      in_window;
    logic                      misaligned;
    logic                      req_err;
    logic                      mem_we;
    logic [3:0]                mem_be;
    logic [31:0]               mem_rdata;

    assign accept = hsel & hready &
                    ((htrans == SCR1_HTRANS_NONSEQ) | (htrans == SCR1_HTRANS_SEQ));

    // Offset from the window base; in range when no bits above the array remain.
    assign addr_off   = haddr - BASE_ADDR;
    assign in_window  = (addr_off >> (MEM_AW + 2)) == '0;
    assign misaligned = ((hsize == SCR1_HSIZE_16BIT) & haddr[0]) |
                        ((hsize == SCR1_HSIZE_32BIT) & (haddr[1:0] != 2'b00));
    assign req_err    = (hsize > SCR1_HSIZE_32BIT) | misaligned | ~in_window;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        boff_d  = boff_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            SCR1_AHB_SLV_FSM_IDLE,
            SCR1_AHB_SLV_FSM_DONE,
            SCR1_AHB_SLV_FSM_ERR2: begin
                state_d = SCR1_AHB_SLV_FSM_IDLE;
                if (accept) begin
                    waddr_d = addr_off[MEM_AW+1:2];
                    boff_d  = haddr[1:0];
                    size_d  = hsize;
                    write_d = hwrite;
                    if (req_err) begin
                        state_d = SCR1_AHB_SLV_FSM_ERR1;
                    end else if ((WAIT_STATES > 0) || stall) begin
                        state_d = SCR1_AHB_SLV_FSM_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = SCR1_AHB_SLV_FSM_DONE;
                    end
                end
            end
            SCR1_AHB_SLV_FSM_WAIT: begin
                // Exit on the cycle the count reaches zero, so WAIT_STATES
                // low cycles are seen; stall only blocks the exit.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if ((cnt_q <= 4'd1) && !stall) begin
                    state_d = SCR1_AHB_SLV_FSM_DONE;
                end
            end
            SCR1_AHB_SLV_FSM_ERR1: begin
                state_d = SCR1_AHB_SLV_FSM_ERR2;
            end
            default: begin
                state_d = SCR1_AHB_SLV_FSM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCR1_AHB_SLV_FSM_IDLE;
            cnt_q   <= 4'd0;
            waddr_q <= '0;
            boff_q  <= 2'b00;
            size_q  <= SCR1_HSIZE_8BIT;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            boff_q  <= boff_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    assign mem_we = (state_q == SCR1_AHB_SLV_FSM_DONE) & write_q;
    assign mem_be = scr1_ahb_byte_en(size_q, boff_q);

    scr1_sram_1rw_be #(
        .AW (MEM_AW)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (waddr_q),
        .wdata (hwdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        hreadyout = 1'b1;
        hresp     = SCR1_HRESP_OKAY;
        hrdata    = '0;
        case (state_q)
            SCR1_AHB_SLV_FSM_WAIT: hreadyout = 1'b0;
            SCR1_AHB_SLV_FSM_DONE: begin
                if (!write_q) begin
                    hrdata = mem_rdata;
                end
            end
            SCR1_AHB_SLV_FSM_ERR1: begin
                hreadyout = 1'b0;
                hresp     = SCR1_HRESP_ERROR;
            end
            SCR1_AHB_SLV_FSM_ERR2: hresp = SCR1_HRESP_ERROR;
            default: ;
        endcase
    end

endmodule

// File: doc/scr1_ahb_sram_slave.md
Name: scr1_ahb_sram_slave

Overview:
- Synthesizable AHB-Lite responder with a word-organized SRAM behind it.
- It is the slave end of the SCR1 imem/dmem AHB ports. It replaces the behavioural testbench memory in FPGA/emulation builds and gives a cycle-exact, checkable responder.
- Supports byte/halfword/word accesses, configurable wait states, an external stall input and AHB two-cycle ERROR responses.

Parameters:
- MEM_AW, 14, log2 of memory depth in 32-bit words (default is 64 KiB).
- WAIT_STATES, 0, fixed number of hreadyout-low cycles inserted per OKAY data phase (0..15).
- BASE_ADDR, 32'h0, base of the decoded window; accesses outside BASE_ADDR .. BASE_ADDR+4*2^MEM_AW-1 return ERROR.

Ports:
- clk, in, 1, core clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- hsel, in, 1, slave select.
- haddr, in, 32, address-phase address.
- htrans, in, 2, IDLE/BUSY/NONSEQ/SEQ.
- hsize, in, 3, transfer size; 0/1/2 legal.
- hwrite, in, 1, 1 = write.
- hwdata, in, 32, write data, valid in the data phase.
- hready, in, 1, bus ready; loop back hreadyout in a single-slave system.
- stall, in, 1, verification stall; while high, a pending OKAY data phase holds hreadyout low.
- hreadyout, out, 1, data phase complete.
- hrdata, out, 32, read data.
- hresp, out, 1, 0 = OKAY, 1 = ERROR (SCR1 1-bit encoding).

Behaviour:
- Reset values (asynchronous, while rst_n = 0):
  - hreadyout = 1, hresp = 0, hrdata = 0, FSM = IDLE, wait counter = 0.
  - Memory contents are not reset.
- Address-phase capture:
  - A transfer is accepted on a clk edge when hsel & hready & htrans[1].
  - On acceptance, latch haddr, hsize, hwrite and an error flag.
  - IDLE/BUSY, or hsel = 0, with hready high give a zero-wait OKAY and no memory access.
- Error conditions (any one sets the flag):
  - hsize > 2.
  - Misaligned access: hsize = 1 with haddr[0] = 1, or hsize = 2 with haddr[1:0] != 0.
  - Address outside the decoded window.
- FSM states: IDLE, WAIT, DONE, ERR1, ERR2.
  - IDLE: hreadyout = 1, hresp = 0.
    - Accept with error flag -> ERR1.
    - Accept with (WAIT_STATES > 0 or stall) -> WAIT, counter loaded with WAIT_STATES.
    - Accept otherwise -> DONE.
  - WAIT: hreadyout = 0.
    - Counter decrements each cycle while nonzero.
    - Go to DONE when counter == 0 and stall == 0.
    - stall freezes the exit but not the decrement.
  - DONE: hreadyout = 1, hresp = 0; the transfer completes this cycle.
    - A new accepted transfer is handled exactly as from IDLE (back-to-back pipelining).
    - Otherwise -> IDLE.
  - ERR1: hreadyout = 0, hresp = 1 -> ERR2.
  - ERR2: hreadyout = 1, hresp = 1.
    - A new transfer may be accepted here (master may cancel by driving IDLE), handled as from IDLE.
    - Otherwise -> IDLE.
    - ERROR transfers never write memory.
- Write commit:
  - Occurs at the clk edge ending DONE for a latched write.
  - Byte enables come from latched haddr[1:0] and hsize: byte = 1 lane, halfword = 2 lanes, word = all lanes.
  - Only the enabled hwdata lanes are written.
- Read data:
  - hrdata = array[latched word address] during DONE for a read, else 0.
  - The array read is asynchronous from the latched address. A write committed at the end of a DONE is therefore visible to a read whose DONE is the next cycle (read-after-write with zero bubbles).
- Reset mid-transfer: FSM returns to IDLE immediately; no write is committed.
- Signals outside their valid phases (hwdata outside write data phases, haddr when not accepted) must not affect any state.

Decomposition:
- SCR1_AHB_WIDTH, the htrans encodings (SCR1_HTRANS_IDLE/NONSEQ/...), the hsize encodings and the hresp encodings come from the shared scr1_ahb.svh.
- Add an FSM state enum type_scr1_ahb_slv_fsm_e to that header.
- Sub-module scr1_sram_1rw_be: 2^MEM_AW x 32 array with 4-bit byte-enable synchronous write and asynchronous read, reusable for FPGA inference.

Test Plan:
1. rst_n low for 3 cycles then high, idle bus -> hreadyout = 1, hresp = 0, hrdata = 0 throughout.
2. WAIT_STATES = 0: NONSEQ word write of 0xDEADBEEF to 0x10, immediately followed by a NONSEQ word read of 0x10 -> both complete with no hreadyout-low cycle; read DONE shows hrdata = 0xDEADBEEF.
3. Byte write 0xAA to 0x13, then word read of 0x10 -> hrdata = 0xAAADBEEF. Halfword write 0x1234 to 0x10, then word read -> 0xAAAD1234.
4. WAIT_STATES = 2: read of 0x10 -> hreadyout low exactly 2 cycles, then high with the data.
   - Same test with stall held high for 5 cycles -> hreadyout low 5 cycles.
5. Halfword write to 0x11, and word read at BASE_ADDR + 4*2^MEM_AW -> each gives the ERR1 then ERR2 sequence (hreadyout 0/1, hresp 1/1); re-reading 0x10 returns unchanged data.
6. Two stimuli:
   - hsel = 0 with htrans = NONSEQ, or hsel = 1 with htrans = BUSY -> OKAY, zero wait, memory unchanged.
   - rst_n asserted during WAIT of a pending write -> hreadyout = 1 at once and the target word is unchanged afterwards.
